// File: rtl/io_pkg.sv
// Shared I/O definitions for the core bus peripherals.
//  - address map of the UART transmitter registers
//  - 2-bit transmitter FSM state encoding
//  - control register bit positions
//  - baud divisor helper (rounded to nearest clock count)
package io_pkg;

  localparam logic [31:0] UART_DATA_ADDR = 32'h0000_0020;
  localparam logic [31:0] UART_CTRL_ADDR = 32'h0000_0024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int unsigned CTRL_CLR_OVF = 0;
  localparam int unsigned CTRL_FLUSH   = 1;

  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// Core I/O bus write channel as seen by a memory-mapped peripheral.
//  addr        bus address
//  data        bus write data
//  writeEnable write strobe (level; may stay high for many cycles)
// master: the core driving the bus; slave: the peripheral.
interface io_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] data;
  logic        writeEnable;

  modport master (output addr, output data, output writeEnable);
  modport slave  (input  addr, input  data, input  writeEnable);
endinterface

// File: rtl/io_fifo.sv
// Synchronous first-word-fall-through FIFO.
//  clk, rst  clock, synchronous active-high reset
//  push/din  write an entry (ignored when full unless popping same cycle)
//  pop       discard the head entry (ignored when empty)
//  flush     empty the FIFO (pointers reset), overrides push/pop
//  dout      head entry, valid while !empty
//  empty/full occupancy flags
module io_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core I/O bus.
//  clk, rst     clock, synchronous active-high reset
//  bus          write channel (addr/data/writeEnable), slave side
//  txd          serial output, idle high
//  busy         frame in progress or bytes queued
//  fifoFull     transmit FIFO holds FIFO_DEPTH entries
//  overflow     sticky: a data write was dropped on a full FIFO
// BASE_ADDR is the data register, BASE_ADDR+4 the control register
// (bit0 clears overflow, bit1 flushes the queue).
module io_uart_tx
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = UART_DATA_ADDR,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  io_uart_tx_if.slave    bus,
  output logic           txd,
  output logic           busy,
  output logic           fifoFull,
  output logic           overflow
);

  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;
  localparam int unsigned DIV       = baud_div(CLK_HZ, BAUD);
  localparam int unsigned CW        = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

  // Write edge detect: one action per contiguous run of hits on one address.
  logic        prev_hit_q, prev_hit_d;
  logic [31:0] prev_addr_q, prev_addr_d;
  logic        hit, act;

  // Decoded write, registered once before it reaches the FIFO/overflow flag.
  logic        wr_data_q, wr_data_d;
  logic [7:0]  wr_byte_q, wr_byte_d;
  logic        clr_ovf_q, clr_ovf_d;
  logic        flush_q, flush_d;

  logic        overflow_q, overflow_d;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_full;

  logic unused_data_hi;
  assign unused_data_hi = ^bus.data[31:8];

  assign hit = bus.writeEnable && ((bus.addr == BASE_ADDR) || (bus.addr == CTRL_ADDR));
  assign act = hit && (!prev_hit_q || (bus.addr != prev_addr_q));

  always_comb begin
    prev_hit_d  = hit;
    prev_addr_d = bus.addr;
    wr_data_d   = act && (bus.addr == BASE_ADDR);
    wr_byte_d   = bus.data[7:0];
    clr_ovf_d   = act && (bus.addr == CTRL_ADDR) && bus.data[CTRL_CLR_OVF];
    flush_d     = act && (bus.addr == CTRL_ADDR) && bus.data[CTRL_FLUSH];
  end

  io_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data_q),
    .pop   (fifo_pop),
    .flush (flush_q),
    .din   (wr_byte_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf_q) overflow_d = 1'b0;
    else if (wr_data_q && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  // Serialiser: every bit held for DIV clocks; a queued byte following a
  // stop bit goes straight to START so frames abut without an idle gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          txd_d    = 1'b0;
          cnt_d    = DIV_M1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = DIV_M1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            txd_d    = 1'b0;
            cnt_d    = DIV_M1;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_hit_q  <= 1'b0;
      prev_addr_q <= '0;
      wr_data_q   <= 1'b0;
      wr_byte_q   <= '0;
      clr_ovf_q   <= 1'b0;
      flush_q     <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
    end else begin
      prev_hit_q  <= prev_hit_d;
      prev_addr_q <= prev_addr_d;
      wr_data_q   <= wr_data_d;
      wr_byte_q   <= wr_byte_d;
      clr_ovf_q   <= clr_ovf_d;
      flush_q     <= flush_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
    end
  end

  assign txd      = txd_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign fifoFull = fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx at CLK_HZ=1000, BAUD=100 (10 clocks/bit),
// FIFO_DEPTH=4. Inputs change and outputs are sampled on the falling edge.
module tb_io_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd, busy, fifoFull, overflow;

  int checks = 0;
  int errors = 0;

  io_uart_tx_if bus_if ();

  io_uart_tx #(
    .BASE_ADDR  (32'h0000_0020),
    .CLK_HZ     (1000),
    .BAUD       (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .txd      (txd),
    .busy     (busy),
    .fifoFull (fifoFull),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle strobe then one idle cycle; called and returns on a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.addr        = a;
    bus_if.data        = d;
    bus_if.writeEnable = 1'b1;
    @(negedge clk);
    bus_if.writeEnable = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (txd === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check({tag, " start timeout"}, {31'd0, txd}, 32'd0);
  endtask

  // Entered on the first sample of the start bit; checks first and last
  // sample of every bit, returns on the first sample after the stop bit.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      check($sformatf("%s bit%0d first", tag, j), {31'd0, txd}, {31'd0, bits[j]});
      tick(9);
      check($sformatf("%s bit%0d last", tag, j), {31'd0, txd}, {31'd0, bits[j]});
      tick(1);
    end
  endtask

  initial begin
    bus_if.addr        = '0;
    bus_if.data        = '0;
    bus_if.writeEnable = 1'b0;

    // Reset state
    tick(3);
    check("rst txd", {31'd0, txd}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst full", {31'd0, fifoFull}, 32'd0);
    check("rst ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: single write 0xA5, exact two-edge latency
    bus_if.addr = 32'h20; bus_if.data = 32'hFFFF_FFA5; bus_if.writeEnable = 1'b1;
    tick(1);
    bus_if.writeEnable = 1'b0;
    check("t1 lat n txd", {31'd0, txd}, 32'd1);
    tick(1);
    check("t1 lat n1 txd", {31'd0, txd}, 32'd1);
    check("t1 lat n1 busy", {31'd0, busy}, 32'd1);
    tick(1);
    check_frame("t1 A5", 8'hA5);
    check("t1 busy after", {31'd0, busy}, 32'd0);
    tick(5);

    // 2: strobe held 50 cycles -> exactly one frame
    fork
      begin
        bus_if.addr = 32'h20; bus_if.data = 32'h3C; bus_if.writeEnable = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          check("t2 hold full", {31'd0, fifoFull}, 32'd0);
        end
        bus_if.writeEnable = 1'b0;
      end
      begin
        wait_start("t2");
        check_frame("t2 3C", 8'h3C);
      end
    join
    for (int i = 0; i < 30; i++) begin
      check("t2 idle txd", {31'd0, txd}, 32'd1);
      check("t2 idle busy", {31'd0, busy}, 32'd0);
      tick(1);
    end
    check("t2 ovf", {31'd0, overflow}, 32'd0);

    // 3: six writes while busy -> 5 frames back to back, 0x06 dropped
    fork
      begin
        for (int k = 1; k <= 6; k++) bus_write(32'h20, k);
        tick(2);
        check("t3 full", {31'd0, fifoFull}, 32'd1);
        check("t3 ovf", {31'd0, overflow}, 32'd1);
      end
      begin
        wait_start("t3");
        for (int k = 1; k <= 5; k++) check_frame($sformatf("t3 f%0d", k), 8'(k));
      end
    join
    check("t3 busy after", {31'd0, busy}, 32'd0);
    check("t3 full after", {31'd0, fifoFull}, 32'd0);
    check("t3 ovf sticky", {31'd0, overflow}, 32'd1);
    tick(5);
    check("t3 no extra", {31'd0, txd}, 32'd1);

    // 4a: clear overflow
    bus_write(32'h24, 32'h1);
    check("t4 ovf clr", {31'd0, overflow}, 32'd0);

    // 4b: flush mid-frame with three queued
    fork
      begin
        bus_write(32'h20, 32'h11);
        bus_write(32'h20, 32'h22);
        bus_write(32'h20, 32'h33);
        bus_write(32'h20, 32'h44);
        tick(30);
        bus_write(32'h24, 32'h2);
        check("t4 flush full", {31'd0, fifoFull}, 32'd0);
        check("t4 flush busy", {31'd0, busy}, 32'd1);
      end
      begin
        wait_start("t4");
        check_frame("t4 11", 8'h11);
        check("t4 busy after", {31'd0, busy}, 32'd0);
      end
    join
    for (int i = 0; i < 30; i++) begin
      check("t4 idle txd", {31'd0, txd}, 32'd1);
      tick(1);
    end
    check("t4 idle busy", {31'd0, busy}, 32'd0);

    // 5: reset during data bit 3 of 0xFF with two queued
    bus_write(32'h20, 32'hFF);
    bus_write(32'h20, 32'h01);
    bus_write(32'h20, 32'h02);
    tick(42);
    check("t5 pre busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("t5 rst txd", {31'd0, txd}, 32'd1);
    check("t5 rst busy", {31'd0, busy}, 32'd0);
    check("t5 rst full", {31'd0, fifoFull}, 32'd0);
    check("t5 rst ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      check("t5 quiet txd", {31'd0, txd}, 32'd1);
      check("t5 quiet busy", {31'd0, busy}, 32'd0);
    end

    // 6: non-matching addresses ignored
    bus_write(32'h28, 32'h55);
    bus_write(32'h00, 32'h55);
    for (int i = 0; i < 20; i++) begin
      check("t6 txd", {31'd0, txd}, 32'd1);
      check("t6 busy", {31'd0, busy}, 32'd0);
      tick(1);
    end
    check("t6 ovf", {31'd0, overflow}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
